// File: rtl/irq_timer_pkg.sv
// Shared definitions for the interrupt timer: FSM encoding, register offsets,
// CTRL field layout and MODE codes.
package irq_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/irq_timer_if.sv
// Register bus seen by the timer: word-addressed write port, combinational
// read data and the interrupt line.
interface irq_timer_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, output we, output wdata, input rdata, input irq);
    modport slave  (input addr, input we, input wdata, output rdata, output irq);
endinterface

// File: rtl/irq_timer.sv
// Programmable down-counter with one-shot / auto-reload modes raising a
// maskable interrupt on expiry.
module irq_timer
    import irq_timer_pkg::*;
#(
    parameter int ADDR_LSB = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_t      state, state_nxt;
    ctrl_t       ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_pend;

    logic [1:0]  offset;
    logic        wr_ctrl, wr_preset, auto_reload;
    logic        load_cnt, dec_cnt, expire, clr_pend_hw, clr_en_hw;
    logic        unused_addr;

    assign offset      = addr[ADDR_LSB+1:ADDR_LSB];
    assign unused_addr = ^addr;
    assign wr_ctrl     = we && (offset == OFF_CTRL);
    assign wr_preset   = we && (offset == OFF_PRESET);
    assign auto_reload = (ctrl.mode == MODE_RELOAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ctrl.en) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_CNT;
            ST_CNT: begin
                if (!ctrl.en)            state_nxt = ST_IDLE;
                else if (count <= 32'd1) state_nxt = ST_INT;
            end
            ST_INT:  state_nxt = auto_reload ? ST_LOAD : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load_cnt    = 1'b0;
        dec_cnt     = 1'b0;
        expire      = 1'b0;
        clr_pend_hw = 1'b0;
        clr_en_hw   = 1'b0;
        case (state)
            ST_LOAD: load_cnt = 1'b1;
            ST_CNT: begin
                if (ctrl.en) begin
                    dec_cnt = (count > 32'd1);
                    expire  = (count <= 32'd1);
                end
            end
            ST_INT: begin
                clr_pend_hw = auto_reload;
                clr_en_hw   = !auto_reload;
            end
            default: ;
        endcase
    end

    // Software CTRL writes take priority over the hardware EN clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl   <= '0;
            preset <= '0;
        end else begin
            if (wr_ctrl)        ctrl    <= ctrl_t'(wdata[3:0]);
            else if (clr_en_hw) ctrl.en <= 1'b0;
            if (wr_preset)      preset  <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        count <= '0;
        else if (load_cnt) count <= preset;
        else if (dec_cnt)  count <= count - 32'd1;
        else if (expire)   count <= '0;
    end

    // A set on the expiry edge beats any clear so no interrupt is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                    irq_pend <= 1'b0;
        else if (expire)                               irq_pend <= 1'b1;
        else if (wr_ctrl || wr_preset || clr_pend_hw)  irq_pend <= 1'b0;
    end

    always_comb begin
        rdata = '0;
        case (offset)
            OFF_CTRL:   rdata = {28'd0, ctrl};
            OFF_PRESET: rdata = preset;
            OFF_COUNT:  rdata = count;
            default:    rdata = '0;
        endcase
    end

    assign irq = irq_pend & ctrl.im;

endmodule

// File: tb/tb_irq_timer.sv
// Scenario bench for irq_timer: per-cycle expectations queued at stimulus
// time and popped as the counter advances.
module tb_irq_timer;
    import irq_timer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    irq_timer_if bus();

    irq_timer #(.ADDR_LSB(2)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (bus.addr),
        .we    (bus.we),
        .wdata (bus.wdata),
        .rdata (bus.rdata),
        .irq   (bus.irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_cnt_q[$];
    logic        exp_irq_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [1:0] off);
        bus.addr = ($urandom() & 32'hFFFF_FFF0) | (32'(off) << 2);
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        set_addr(off);
        bus.wdata = d;
        bus.we    = 1'b1;
        step();
        bus.we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] d);
        set_addr(off);
        #1;
        d = bus.rdata;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        bus.we = 1'b0;
        bus.wdata = '0;
        set_addr(OFF_CTRL);
        #1 reset = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), d);
            n_checks++;
            if (d !== 32'd0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 0", i, d); end
        end
        n_checks++;
        if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
        step();
        reset = 1'b1;
        wr(OFF_PRESET, 32'd7);
        repeat (5) step();
        rd(OFF_COUNT, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL idle_no_en_count: got %0d expected 0", d); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        do_reset();
        wr(OFF_PRESET, 32'hDEAD_BEEF);
        rd(OFF_PRESET, d);
        n_checks++;
        if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL preset_rw: got %h expected deadbeef", d); end
        wr(OFF_COUNT, 32'h55);
        wr(2'd3, 32'h66);
        rd(OFF_COUNT, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL count_ro: got %h expected 0", d); end
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL off3_zero: got %h expected 0", d); end
        wr(OFF_CTRL, 32'hFFFF_FFF6);
        rd(OFF_CTRL, d);
        n_checks++;
        if (d !== 32'h6) begin n_fail++; $display("FAIL ctrl_mask: got %h expected 6", d); end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        do_reset();
        wr(OFF_PRESET, 32'd5);
        wr(OFF_CTRL, 32'h9);
        for (int k = 1; k <= 7; k++) begin
            exp_irq_q.push_back(k == 7);
            exp_cnt_q.push_back((k >= 2 && k <= 6) ? 32'(7 - k) : 32'd0);
        end
        for (int k = 1; k <= 7; k++) begin
            logic [31:0] ec;
            logic        ei;
            step();
            ec = exp_cnt_q.pop_front();
            ei = exp_irq_q.pop_front();
            rd(OFF_COUNT, d);
            n_checks++;
            if (d !== ec) begin n_fail++; $display("FAIL oneshot_count edge%0d: got %0d expected %0d", k, d, ec); end
            n_checks++;
            if (bus.irq !== ei) begin n_fail++; $display("FAIL oneshot_irq edge%0d: got %b expected %b", k, bus.irq, ei); end
        end
        step();
        rd(OFF_CTRL, d);
        n_checks++;
        if (d !== 32'h8) begin n_fail++; $display("FAIL oneshot_en_clr: got %h expected 8", d); end
        repeat (3) step();
        n_checks++;
        if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq_hold: got %b expected 1", bus.irq); end
        wr(OFF_CTRL, 32'h0);
        n_checks++;
        if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_clr: got %b expected 0", bus.irq); end
    endtask

    task automatic test_autoreload();
        int pulses = 0;
        do_reset();
        wr(OFF_PRESET, 32'd3);
        wr(OFF_CTRL, 32'hB);
        for (int k = 1; k <= 21; k++) exp_irq_q.push_back((k % 5) == 0);
        for (int k = 1; k <= 21; k++) begin
            logic ei;
            step();
            ei = exp_irq_q.pop_front();
            if (bus.irq === 1'b1) pulses++;
            n_checks++;
            if (bus.irq !== ei) begin n_fail++; $display("FAIL reload_irq edge%0d: got %b expected %b", k, bus.irq, ei); end
        end
        n_checks++;
        if (pulses != 4) begin n_fail++; $display("FAIL reload_pulses: got %0d expected 4", pulses); end
        wr(OFF_CTRL, 32'h0);
    endtask

    task automatic test_mask();
        logic [31:0] d;
        do_reset();
        wr(OFF_PRESET, 32'd2);
        wr(OFF_CTRL, 32'h1);
        for (int k = 1; k <= 8; k++) exp_irq_q.push_back(1'b0);
        for (int k = 1; k <= 8; k++) begin
            logic ei;
            step();
            ei = exp_irq_q.pop_front();
            n_checks++;
            if (bus.irq !== ei) begin n_fail++; $display("FAIL mask_irq edge%0d: got %b expected %b", k, bus.irq, ei); end
        end
        rd(OFF_CTRL, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL mask_idle_ctrl: got %h expected 0", d); end
        wr(OFF_CTRL, 32'h8);
        repeat (4) begin
            step();
            n_checks++;
            if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL mask_after_im: got %b expected 0", bus.irq); end
        end
    endtask

    task automatic test_pause();
        logic [31:0] d;
        do_reset();
        wr(OFF_PRESET, 32'd10);
        wr(OFF_CTRL, 32'h1);
        repeat (4) step();
        wr(OFF_CTRL, 32'h0);
        repeat (3) step();
        rd(OFF_COUNT, d);
        n_checks++;
        if (d !== 32'd7) begin n_fail++; $display("FAIL pause_hold: got %0d expected 7", d); end
        wr(OFF_PRESET, 32'd100);
        wr(OFF_CTRL, 32'h1);
        step();
        rd(OFF_COUNT, d);
        n_checks++;
        if (d !== 32'd7) begin n_fail++; $display("FAIL pause_load_cycle: got %0d expected 7", d); end
        step();
        rd(OFF_COUNT, d);
        n_checks++;
        if (d !== 32'd100) begin n_fail++; $display("FAIL pause_reload: got %0d expected 100", d); end
        step();
        rd(OFF_COUNT, d);
        n_checks++;
        if (d !== 32'd99) begin n_fail++; $display("FAIL pause_dec: got %0d expected 99", d); end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        do_reset();
        wr(OFF_PRESET, 32'd5);
        wr(OFF_CTRL, 32'h9);
        repeat (6) step();
        wr(OFF_CTRL, 32'h9);
        rd(OFF_CTRL, d);
        n_checks++;
        if (d !== 32'h9) begin n_fail++; $display("FAIL coll_expiry_en: got %h expected 9", d); end
        n_checks++;
        if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL coll_expiry_irq: got %b expected 1", bus.irq); end
        step();
        n_checks++;
        if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL coll_irq_hold: got %b expected 1", bus.irq); end
        do_reset();
        wr(OFF_PRESET, 32'd5);
        wr(OFF_CTRL, 32'h9);
        repeat (7) step();
        wr(OFF_CTRL, 32'h9);
        rd(OFF_CTRL, d);
        n_checks++;
        if (d !== 32'h9) begin n_fail++; $display("FAIL coll_int_en: got %h expected 9", d); end
        n_checks++;
        if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL coll_int_irq: got %b expected 0", bus.irq); end
        repeat (2) step();
        rd(OFF_COUNT, d);
        n_checks++;
        if (d !== 32'd5) begin n_fail++; $display("FAIL coll_restart: got %0d expected 5", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        do_reset();
        wr(OFF_PRESET, 32'd50);
        wr(OFF_CTRL, 32'h9);
        repeat (12) step();
        rd(OFF_COUNT, d);
        n_checks++;
        if (d !== 32'd40) begin n_fail++; $display("FAIL rstmid_pre: got %0d expected 40", d); end
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd(2'(i), d);
            n_checks++;
            if (d !== 32'd0) begin n_fail++; $display("FAIL rstmid_reg%0d: got %h expected 0", i, d); end
        end
        step();
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            n_checks++;
            if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL rstmid_irq cyc%0d: got %b expected 0", k, bus.irq); end
        end
        rd(OFF_COUNT, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL rstmid_idle_count: got %0d expected 0", d); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_oneshot();
        test_autoreload();
        test_mask();
        test_pause();
        test_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
